// File: rtl/nes_bus_pkg.sv
// Shared NES bus definitions: OAM DMA state encoding, bus addresses and
// transfer lengths. The ALIGN state only exists when OAM_DMA_ALIGN_EN is defined.
package nes_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
`ifdef OAM_DMA_ALIGN_EN
    ST_ALIGN,
`endif
    ST_READ,
    ST_WRITE
  } dma_state_e;

  localparam logic [15:0] DMA_TRIGGER_ADDR_DEF = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR_DEF    = 16'h2004;

  // CPU cycles the core is held off: HALT + 256 x (READ, WRITE), plus ALIGN
  // when HALT ends on a put cycle.
  localparam int DMA_CYCLES_ON_GET = 513;
  localparam int DMA_CYCLES_ON_PUT = 514;

endpackage

// File: rtl/cpu_cycle_parity.sv
// Get/put cycle tracker: 0 = get (read) cycle, 1 = put (write) cycle.
module cpu_cycle_parity (
  input  logic clk,
  input  logic rst,
  input  logic ph2_falling,
  output logic parity
);

  // flip at every CPU-cycle boundary
  always_ff @(posedge clk) begin
    if (rst)              parity <= 1'b0;
    else if (ph2_falling) parity <= ~parity;
  end

endmodule

// File: rtl/oam_dma_controller.sv
// OAM DMA controller: a CPU write to DMA_TRIGGER_ADDR halts the CPU and copies
// page {data,00..FF} to OAM_DATA_ADDR, one read/write pair per two CPU cycles.
// Define OAM_DMA_ALIGN_EN to insert an ALIGN cycle when HALT ends on a put cycle.
module oam_dma_controller
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_TRIGGER_ADDR = DMA_TRIGGER_ADDR_DEF,
  parameter logic [15:0] OAM_DATA_ADDR    = OAM_DATA_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ph2_rising,
  input  logic        ph2_falling,
  input  logic [15:0] cpu_addr_in,
  input  logic        cpu_rnw_in,
  input  logic [7:0]  cpu_data_in,
  input  logic [7:0]  mem_data_in,
  output logic        cpu_rdy,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic        dma_rnw,
  output logic [7:0]  dma_data_out
);

  dma_state_e state;
  logic [7:0] page;
  logic [7:0] index;
  logic [7:0] data_byte;
  logic       rise_seen;
  logic       parity;
  logic       trigger;
  logic       capture;
  logic [7:0] index_nxt;

  cpu_cycle_parity u_parity (
    .clk         (clk),
    .rst         (rst),
    .ph2_falling (ph2_falling),
    .parity      (parity)
  );

`ifndef OAM_DMA_ALIGN_EN
  logic cyc_parity_unused;
  assign cyc_parity_unused = parity;
`endif

  assign trigger   = (state == ST_IDLE) && !cpu_rnw_in && (cpu_addr_in == DMA_TRIGGER_ADDR);
  // read data is only valid if phase 2 actually started in this READ cycle
  assign capture   = rise_seen || ph2_rising;
  assign index_nxt = index + 8'd1;

  // transfer FSM; all bus outputs are registered and change at cycle boundaries
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      page         <= 8'h00;
      index        <= 8'h00;
      data_byte    <= 8'h00;
      rise_seen    <= 1'b0;
      cpu_rdy      <= 1'b1;
      dma_active   <= 1'b0;
      dma_addr     <= 16'h0000;
      dma_rnw      <= 1'b1;
      dma_data_out <= 8'h00;
    end else begin
      if (ph2_rising && state == ST_READ) rise_seen <= 1'b1;
      if (ph2_falling) begin
        rise_seen <= 1'b0;
        case (state)
          ST_IDLE: begin
            if (trigger) begin
              page    <= cpu_data_in;
              index   <= 8'h00;
              cpu_rdy <= 1'b0;
              state   <= ST_HALT;
            end
          end
          ST_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
            // next cycle is a put: burn one more cycle so READ lands on a get
            if (!parity) begin
              state <= ST_ALIGN;
            end else
`endif
            begin
              state      <= ST_READ;
              dma_active <= 1'b1;
              dma_addr   <= {page, index};
              dma_rnw    <= 1'b1;
            end
          end
`ifdef OAM_DMA_ALIGN_EN
          ST_ALIGN: begin
            state      <= ST_READ;
            dma_active <= 1'b1;
            dma_addr   <= {page, index};
            dma_rnw    <= 1'b1;
          end
`endif
          ST_READ: begin
            if (capture) data_byte <= mem_data_in;
            state        <= ST_WRITE;
            dma_addr     <= OAM_DATA_ADDR;
            dma_rnw      <= 1'b0;
            dma_data_out <= capture ? mem_data_in : data_byte;
          end
          ST_WRITE: begin
            index        <= index_nxt;
            dma_data_out <= 8'h00;
            dma_rnw      <= 1'b1;
            if (index == 8'hFF) begin
              state      <= ST_IDLE;
              cpu_rdy    <= 1'b1;
              dma_active <= 1'b0;
              dma_addr   <= 16'h0000;
            end else begin
              state    <= ST_READ;
              dma_addr <= {page, index_nxt};
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench for oam_dma_controller: full transfers on get/put parity,
// page FF, mid-transfer reset, non-trigger accesses and re-trigger during DMA.
module tb_oam_dma_controller;

`ifdef OAM_DMA_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ph2_rising = 1'b0;
  logic        ph2_falling = 1'b0;
  logic [15:0] cpu_addr_in = 16'h0000;
  logic        cpu_rnw_in = 1'b1;
  logic [7:0]  cpu_data_in = 8'h00;
  logic [7:0]  mem_data_in = 8'h00;
  logic        cpu_rdy;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic        dma_rnw;
  logic [7:0]  dma_data_out;

  oam_dma_controller dut (
    .clk          (clk),
    .rst          (rst),
    .ph2_rising   (ph2_rising),
    .ph2_falling  (ph2_falling),
    .cpu_addr_in  (cpu_addr_in),
    .cpu_rnw_in   (cpu_rnw_in),
    .cpu_data_in  (cpu_data_in),
    .mem_data_in  (mem_data_in),
    .cpu_rdy      (cpu_rdy),
    .dma_active   (dma_active),
    .dma_addr     (dma_addr),
    .dma_rnw      (dma_rnw),
    .dma_data_out (dma_data_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc_num = 0;
  int halt_cnt = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic [7:0] exp_page = 8'h00;
  logic snap_rdy = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // RAM contents: page FF holds inverted low address byte, all others the low byte
  function automatic logic [7:0] memv(input logic [15:0] a);
    return (a[15:8] == 8'hFF) ? ~a[7:0] : a[7:0];
  endfunction

  function automatic int exp_len();
    return (ALIGN_EN && cyc_num[0]) ? 514 : 513;
  endfunction

  // one CPU cycle: ph2_rising, then observe the bus, then ph2_falling
  task automatic cyc(input logic [15:0] a, input logic rnw, input logic [7:0] d);
    cpu_addr_in = a;
    cpu_rnw_in  = rnw;
    cpu_data_in = d;
    @(negedge clk);
    mem_data_in = memv(dma_addr);
    ph2_rising  = 1'b1;
    @(negedge clk);
    ph2_rising  = 1'b0;
    @(negedge clk);
    snap_rdy = cpu_rdy;
    if (!cpu_rdy) halt_cnt++;
    if (dma_active && dma_rnw) begin
      chk("rd_addr", {16'h0, dma_addr}, {16'h0, exp_page, rd_cnt[7:0]});
      rd_cnt++;
    end else if (dma_active) begin
      chk("wr_addr", {16'h0, dma_addr}, 32'h2004);
      chk("wr_data", {24'h0, dma_data_out}, {24'h0, memv({exp_page, wr_cnt[7:0]})});
      wr_cnt++;
    end else begin
      chk("idle_bus", {7'h0, dma_addr, dma_rnw, dma_data_out}, {7'h0, 16'h0, 1'b1, 8'h0});
    end
    ph2_falling = 1'b1;
    @(negedge clk);
    ph2_falling = 1'b0;
    cyc_num++;
  endtask

  task automatic run_dma(input logic [7:0] pg, input bit inject, input int len);
    bit done = 1'b0;
    exp_page = pg;
    halt_cnt = 0;
    wr_cnt   = 0;
    rd_cnt   = 0;
    cyc(16'h4014, 1'b0, pg);
    for (int i = 0; i < 700; i++) begin
      if (inject && i == 100) cyc(16'h4014, 1'b0, 8'h33);
      else                    cyc(16'h0000, 1'b1, 8'h00);
      if (snap_rdy) begin
        done = 1'b1;
        break;
      end
    end
    chk("dma_done", {31'h0, done}, 32'd1);
    chk("halt_len", halt_cnt, len);
    chk("wr_count", wr_cnt, 256);
    chk("rd_count", rd_cnt, 256);
  endtask

  initial begin
    int saved_wr;
    int saved_halt;

    // reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_rdy", {31'h0, cpu_rdy}, 32'd1);
    chk("rst_active", {31'h0, dma_active}, 32'd0);
    chk("rst_bus", {7'h0, dma_addr, dma_rnw, dma_data_out}, {7'h0, 16'h0, 1'b1, 8'h0});
    cyc_num = 0;

    // trigger on a get cycle: always 513
    run_dma(8'h02, 1'b0, 513);

    // trigger on a put cycle
    if (!cyc_num[0]) cyc(16'h0000, 1'b1, 8'h00);
    run_dma(8'h02, 1'b0, ALIGN_EN ? 514 : 513);

    // top page, no wrap into page 00
    run_dma(8'hFF, 1'b0, exp_len());

    // re-trigger write while DMA is running must be ignored
    run_dma(8'h02, 1'b1, exp_len());

    // non-trigger accesses
    halt_cnt = 0;
    cyc(16'h4015, 1'b0, 8'h02);
    cyc(16'h4014, 1'b1, 8'h02);
    repeat (3) cyc(16'h0000, 1'b1, 8'h00);
    chk("no_trig_halt", halt_cnt, 0);
    chk("no_trig_rdy", {31'h0, cpu_rdy}, 32'd1);

    // reset during the WRITE of index 0x80
    exp_page = 8'h02;
    halt_cnt = 0;
    wr_cnt   = 0;
    rd_cnt   = 0;
    cyc(16'h4014, 1'b0, 8'h02);
    for (int i = 0; i < 400 && wr_cnt < 128; i++) cyc(16'h0000, 1'b1, 8'h00);
    cyc(16'h0000, 1'b1, 8'h00);
    @(negedge clk);
    ph2_rising = 1'b1;
    @(negedge clk);
    ph2_rising = 1'b0;
    chk("pre_rst_write", {15'h0, dma_active, dma_rnw, dma_addr}, {15'h0, 1'b1, 1'b0, 16'h2004});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc_num = 0;
    chk("abort_rdy", {31'h0, cpu_rdy}, 32'd1);
    chk("abort_active", {31'h0, dma_active}, 32'd0);
    saved_wr   = wr_cnt;
    saved_halt = halt_cnt;
    repeat (10) cyc(16'h0000, 1'b1, 8'h00);
    chk("abort_no_wr", wr_cnt, saved_wr);
    chk("abort_no_halt", halt_cnt, saved_halt);

    // fresh transfer restarts from index 0
    run_dma(8'h02, 1'b0, exp_len());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
